// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (16-bit word count, big-endian words, XOR checksum)
// and writes the image into instruction memory, holding the CPU until the image checks out.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        imem_busy,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state_reg;
    logic [15:0] len_reg;
    logic [1:0]  byte_idx_reg;
    logic [7:0]  checksum_reg;

    logic        xfer;
    logic [15:0] len_rx;
    logic [15:0] words_next;

    assign xfer       = byte_valid && byte_ready;
    assign len_rx     = {len_reg[15:8], byte_in};
    assign words_next = words_loaded + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            len_reg      <= 16'd0;
            byte_idx_reg <= 2'd0;
            checksum_reg <= 8'd0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            case (state_reg)
                // Terminal states accept a new load exactly like IDLE.
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= 16'd0;
                        checksum_reg <= 8'd0;
                        imem_addr    <= BASE_ADDR;
                        cpu_hold     <= 1'b1;
                        byte_ready   <= 1'b1;
                        state_reg    <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len_reg[15:8] <= byte_in;
                        checksum_reg  <= checksum_reg ^ byte_in;
                        state_reg     <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len_reg[7:0] <= byte_in;
                        checksum_reg <= checksum_reg ^ byte_in;
                        if (len_rx > MAX_LEN) begin
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                            state_reg  <= S_ERROR;
                        end else if (len_rx == 16'd0) begin
                            state_reg <= S_CHECK;
                        end else begin
                            byte_idx_reg <= 2'd0;
                            state_reg    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        imem_wdata   <= {imem_wdata[23:0], byte_in};
                        checksum_reg <= checksum_reg ^ byte_in;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            byte_ready <= 1'b0;
                            state_reg  <= S_WRITE;
                        end
                    end
                end

                // The write strobe doubles as the "already issued" flag for this word.
                S_WRITE: begin
                    if (imem_we) begin
                        imem_we      <= 1'b0;
                        imem_addr    <= imem_addr + 32'd4;
                        words_loaded <= words_next;
                        byte_ready   <= 1'b1;
                        if (words_next == len_reg) begin
                            state_reg <= S_CHECK;
                        end else begin
                            byte_idx_reg <= 2'd0;
                            state_reg    <= S_DATA;
                        end
                    end else if (!imem_busy) begin
                        imem_we <= 1'b1;
                    end
                end

                S_CHECK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_in == checksum_reg) begin
                            done      <= 1'b1;
                            cpu_hold  <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            err       <= 1'b1;
                            cpu_hold  <= 1'b1;
                            state_reg <= S_ERROR;
                        end
                    end
                end

                default: begin
                    byte_ready <= 1'b0;
                    imem_we    <= 1'b0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame-level model (expected writes and outcome derived from the
// byte stream) checked every cycle, plus directed literal cases and randomized frames.
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAXW = 256;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_busy;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .imem_busy(imem_busy),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          wl_model = 0;
    bit          check_en = 0;
    int          busy_mode = 0;
    bit          prev_we = 0;
    bit          exp_ok;
    int          exp_words;
    logic [7:0]  model_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    // Memory busy generator: 0 = never busy, 1 = random, 2 = always busy.
    initial forever begin
        @(posedge clk);
        #2;
        case (busy_mode)
            0:       imem_busy = 1'b0;
            1:       imem_busy = ($urandom % 3 == 0);
            default: imem_busy = 1'b1;
        endcase
    end

    // Per-cycle compare against the frame model.
    initial forever begin
        @(negedge clk);
        if (check_en && reset_n) begin
            if (imem_we) begin
                check("we_one_cycle", {31'd0, prev_we}, 32'd0);
                check("ready_during_write", {31'd0, byte_ready}, 32'd0);
                if (exp_addr.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                             imem_addr, imem_wdata);
                end else begin
                    check("write_addr", imem_addr, exp_addr.pop_front());
                    check("write_data", imem_wdata, exp_data.pop_front());
                end
                obs_addr.push_back(imem_addr);
                obs_data.push_back(imem_wdata);
            end
            check("words_loaded", {16'd0, words_loaded}, 32'(wl_model));
            if (imem_we) wl_model++;
        end
        prev_we = imem_we;
    end

    task automatic build_frame(input int len, input bit good);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'(len >> 8));
        frame_q.push_back(8'(len));
        if (len <= MAXW) begin
            for (int i = 0; i < 4 * len; i++) frame_q.push_back(8'($urandom));
            x = 8'd0;
            foreach (frame_q[k]) x ^= frame_q[k];
            if (!good) x ^= 8'($urandom_range(1, 255));
            frame_q.push_back(x);
        end
    endtask

    // Expected writes and outcome, straight from the frame bytes.
    task automatic model_expect();
        int len;
        int n;
        len = int'({frame_q[0], frame_q[1]});
        exp_addr.delete();
        exp_data.delete();
        model_chk = 8'd0;
        if (len > MAXW) begin
            exp_ok = 0;
            exp_words = 0;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back({frame_q[2 + 4*i], frame_q[3 + 4*i], frame_q[4 + 4*i], frame_q[5 + 4*i]});
            end
            n = frame_q.size();
            for (int k = 0; k < n - 1; k++) model_chk ^= frame_q[k];
            exp_ok = (frame_q[n - 1] == model_chk);
            exp_words = len;
        end
    endtask

    task automatic do_reset();
        check_en = 0;
        reset_n = 1'b0;
        #1;
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
        start = 1'b0;
        byte_valid = 1'b0;
        busy_mode = 0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        obs_addr.delete();
        obs_data.delete();
        wl_model = 0;
        prev_we = 0;
        @(posedge clk);
        #1;
        check_en = 1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wl_model = 0;
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t;
        ok = 1;
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!byte_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!byte_ready) begin
            n_total++;
            $display("FAIL byte_timeout: byte_ready got 0 for %0d cycles, required 1", t);
            byte_valid = 1'b0;
            ok = 0;
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
        end
    endtask

    task automatic run_frame(input int gapmax);
        bit ok;
        model_expect();
        do_start();
        for (int k = 0; k < frame_q.size(); k++) begin
            send_byte(frame_q[k], int'($urandom_range(0, gapmax)), ok);
            if (!ok) begin
                do_reset();
                return;
            end
        end
        @(negedge clk);
        check("end_done", {31'd0, done}, {31'd0, exp_ok});
        check("end_err", {31'd0, err}, {31'd0, !exp_ok});
        check("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_ok});
        check("end_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("end_words_loaded", {16'd0, words_loaded}, 32'(exp_words));
        check("end_writes_pending", 32'(exp_addr.size()), 32'd0);
        $display("frame len=%0d words=%0d ok=%0d done=%0d err=%0d",
                 int'({frame_q[0], frame_q[1]}), exp_words, exp_ok, done, err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset_n = 1'b1;
        start = 1'b0;
        byte_in = 8'd0;
        byte_valid = 1'b0;
        imem_busy = 1'b0;
        #3;
        do_reset();

        // Normal load with model pinned to hand-computed values.
        frame_q = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24, 8'h5B};
        model_expect();
        check("model_chk", {24'd0, model_chk}, 32'h5B);
        check("model_w0", exp_data[0], 32'h00011020);
        check("model_w1", exp_data[1], 32'h00642824);
        check("model_a1", exp_addr[1], 32'h4);
        run_frame(0);
        check("normal_words", {16'd0, words_loaded}, 32'd2);
        check("normal_done", {31'd0, done}, 32'd1);
        check("normal_hold", {31'd0, cpu_hold}, 32'd0);
        check("normal_nwrites", 32'(obs_data.size()), 32'd2);
        if (obs_data.size() >= 2) begin
            check("normal_w0", obs_data[0], 32'h00011020);
            check("normal_a0", obs_addr[0], 32'h0);
            check("normal_w1", obs_data[1], 32'h00642824);
            check("normal_a1", obs_addr[1], 32'h4);
        end

        // Bad checksum.
        frame_q[10] = 8'h5A;
        run_frame(1);
        check("badchk_err", {31'd0, err}, 32'd1);
        check("badchk_done", {31'd0, done}, 32'd0);
        check("badchk_hold", {31'd0, cpu_hold}, 32'd1);
        check("badchk_nwrites", 32'(obs_data.size()), 32'd2);

        // Oversize header.
        frame_q = '{8'h01, 8'h01};
        run_frame(0);
        check("oversize_err", {31'd0, err}, 32'd1);
        check("oversize_nwrites", 32'(obs_data.size()), 32'd0);

        // Backpressure on the first write, with valid gaps mid-word.
        frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        model_expect();
        check("bp_model_chk", {24'd0, model_chk}, 32'h45);
        do_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        send_byte(8'h11, 1, ok);
        send_byte(8'h22, 2, ok);
        send_byte(8'h33, 0, ok);
        busy_mode = 2;
        send_byte(8'h44, 0, ok);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_we_held", {31'd0, imem_we}, 32'd0);
            check("bp_ready_low", {31'd0, byte_ready}, 32'd0);
            check("bp_addr", imem_addr, 32'h0);
            check("bp_data", imem_wdata, 32'h11223344);
            @(posedge clk);
        end
        busy_mode = 0;
        @(negedge clk);
        check("bp_we_still_held", {31'd0, imem_we}, 32'd0);
        @(negedge clk);
        check("bp_we_released", {31'd0, imem_we}, 32'd1);
        check("bp_we_data", imem_wdata, 32'h11223344);
        @(posedge clk);
        #1;
        send_byte(8'h45, 0, ok);
        @(negedge clk);
        check("bp_done", {31'd0, done}, 32'd1);
        check("bp_writes_pending", 32'(exp_addr.size()), 32'd0);
        $display("frame len=1 backpressure done=%0d err=%0d", done, err);
        @(posedge clk);
        #1;

        // Zero length, then a one-word load with a wrong checksum.
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame(0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_nwrites", 32'(obs_data.size()), 32'd0);
        frame_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        run_frame(0);
        check("one_err", {31'd0, err}, 32'd1);
        check("one_done", {31'd0, done}, 32'd0);
        check("one_nwrites", 32'(obs_data.size()), 32'd1);
        if (obs_data.size() >= 1) begin
            check("one_w0", obs_data[0], 32'hAABBCCDD);
            check("one_a0", obs_addr[0], 32'h0);
        end

        // Reset mid-load, then a full load from the base address.
        frame_q = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24, 8'h5B};
        model_expect();
        do_start();
        for (int k = 0; k < 4; k++) send_byte(frame_q[k], 0, ok);
        do_reset();
        run_frame(1);
        check("after_rst_done", {31'd0, done}, 32'd1);
        if (obs_addr.size() >= 1) check("after_rst_a0", obs_addr[0], BASE);

        // Largest accepted image.
        build_frame(MAXW, 1);
        run_frame(0);

        // Randomized frames with random memory backpressure.
        busy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int r;
            int len;
            r = int'($urandom % 10);
            if (r == 0) len = 0;
            else if (r == 1) len = MAXW + 1 + int'($urandom % 50);
            else len = int'($urandom_range(1, 6));
            build_frame(len, ($urandom % 4) != 0);
            run_frame(2);
        end
        busy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
